// File: rtl/rr_arb_mux_2x1.sv
// Registered 2-input round-robin arbiter and data mux with a valid/ready output register.
// Define ARB2_PKT_LOCK_EN to hold the grant on one channel until its beat with last=1 transfers.
module rr_arb_mux_2x1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_sel_q, out_sel_d;
    logic             prio_q, prio_d;     // 0 = A wins contention, 1 = B
    logic             load;
    logic             grant_a, grant_b;

`ifdef ARB2_PKT_LOCK_EN
    logic             lock_q, lock_d;
    logic             lock_ch_q, lock_ch_d;
`else
    logic             unused_last;
    assign unused_last = a_last ^ b_last;
`endif

    always_comb begin
        load    = !out_valid_q || out_ready;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (load) begin
`ifdef ARB2_PKT_LOCK_EN
            if (lock_q) begin
                grant_a = !lock_ch_q && a_valid;
                grant_b = lock_ch_q && b_valid;
            end else
`endif
            if (a_valid && b_valid) begin
                grant_a = !prio_q;
                grant_b = prio_q;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    // Readies are forced low while reset is asserted, even though the register reads empty.
    assign a_ready = rst_n & grant_a;
    assign b_ready = rst_n & grant_b;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        prio_d      = prio_q;
`ifdef ARB2_PKT_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (grant_a || grant_b) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_b ? b_data : a_data;
            out_sel_d   = grant_b;
            prio_d      = grant_a;
`ifdef ARB2_PKT_LOCK_EN
            lock_d      = !(grant_b ? b_last : a_last);
            lock_ch_d   = grant_b;
`endif
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 1'b0;
            prio_q      <= 1'b0;
`ifdef ARB2_PKT_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            prio_q      <= prio_d;
`ifdef ARB2_PKT_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
